sc_row_window: RTL and testbench

//  Parametrised K-row sliding-window generator feeding the stencil compute lanes (sc_r*_k*_2d family).

---
 rtl/sc_pkg.sv | 14 +
 rtl/sc_line_mem.sv | 23 ++
 rtl/sc_row_window.sv | 167 ++++++++++++++++
 tb/tb_sc_row_window.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the stencil row-window block.
package sc_pkg;

    localparam int BW_DEF = 32;
    localparam int ST_DEF = 5;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN, S_DONE} state_e;

    // Width of an index counting 0..n-1, never narrower than one bit.
    function automatic int beat_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sc_line_mem.sv
// One-row delay line: synchronous write, combinational read, one entry per beat of a row.
module sc_line_mem #(
    parameter int W     = 160,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sc_row_window.sv
// K-row sliding window over a raster of ST-lane beats; the live input row forms the bottom
// of the window, the K-1 previous rows come from rotating line memories.
module sc_row_window
    import sc_pkg::*;
#(
    parameter int BW       = BW_DEF,
    parameter int ST       = ST_DEF,
    parameter int ROW      = 8,
    parameter int COL      = 10,
    parameter int K        = 3,
    parameter int PAD_MODE = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                din_ready,
    input  logic [ST*BW-1:0]    din,
    output logic                din_ack,
    output logic [K*ST*BW-1:0]  dout_win,
    output logic                dout_vld,
    input  logic                dout_ready,
    output logic [15:0]         out_row,
    output logic [15:0]         out_col,
    output logic                frame_done
);

    localparam int W         = ST * BW;
    localparam int NB        = COL / ST;
    localparam int H         = (K - 1) / 2;
    localparam int NM        = K - 1;
    localparam int CW        = beat_w(NB);
    localparam int PW        = beat_w(NM);
    localparam int START_ROW = (PAD_MODE != 0) ? H : K - 1;

    if (COL % ST != 0) begin : g_bad_col
        $error("sc_row_window: COL must be a multiple of ST");
    end
    if (K < 3 || K > 7 || K % 2 == 0) begin : g_bad_k
        $error("sc_row_window: K must be odd and within 3..7");
    end

    state_e                state_q;
    logic [15:0]           nr_q, nr_d;
    logic [CW-1:0]         col_q, col_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic                  vld_q, fd_q;
    logic [K-1:0][W-1:0]   win_q, win_d;
    logic [15:0]           orow_q, ocol_q;
    logic [NM-1:0][W-1:0]  rd_data;
    logic                  slot_free, acc, ld, col_last, in_last, drain_last;

    // nr_q is the newest row of the window; past the last input row it keeps
    // counting virtual rows so the drain reuses the same window datapath.
    always_comb begin
        col_last = (col_q == CW'(NB - 1));
        col_d    = col_last ? '0 : col_q + 1'b1;
        nr_d     = col_last ? nr_q + 16'd1 : nr_q;
        wptr_d   = wptr_q;
        if (col_last) wptr_d = (wptr_q == PW'(NM - 1)) ? '0 : wptr_q + 1'b1;
    end

    assign slot_free  = !vld_q || dout_ready;
    assign in_last    = col_last && (nr_q == 16'(ROW - 1));
    assign drain_last = col_last && (nr_q == 16'(ROW - 1 + H));

    always_comb begin
        din_ack = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE, S_FILL: din_ack = 1'b1;
                S_RUN:          din_ack = slot_free;
                default:        din_ack = 1'b0;
            endcase
        end
    end

    assign acc = din_ready && din_ack;
    assign ld  = (state_q == S_RUN && acc) || (state_q == S_DRAIN && slot_free);

    for (genvar i = 0; i < NM; i++) begin : g_mem
        sc_line_mem #(.W(W), .DEPTH(NB), .AW(CW)) u_mem (
            .clk_i   (clock),
            .we_i    (acc && (wptr_q == PW'(i))),
            .waddr_i (col_q),
            .wdata_i (din),
            .raddr_i (col_q),
            .rdata_o (rd_data[i])
        );
    end

    // Row nr-NM+j lives in memory (nr+j) mod NM; rows outside the frame are zeroed,
    // which also hides whatever an abandoned frame left in the memories.
    always_comb begin
        int r;
        int m;
        r     = 0;
        m     = 0;
        win_d = '0;
        for (int j = 0; j < K; j++) begin
            r = int'(nr_q) - NM + j;
            m = int'(wptr_q) + j;
            if (m >= NM) m -= NM;
            if (r >= 0 && r < ROW) win_d[j] = (j == K - 1) ? din : rd_data[m];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            nr_q    <= '0;
            col_q   <= '0;
            wptr_q  <= '0;
            vld_q   <= 1'b0;
            fd_q    <= 1'b0;
            win_q   <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
        end else begin
            fd_q <= 1'b0;
            if (ld) begin
                win_q  <= win_d;
                orow_q <= nr_q - 16'(H);
                ocol_q <= 16'(col_q);
                vld_q  <= 1'b1;
            end else if (dout_ready) begin
                vld_q  <= 1'b0;
            end

            case (state_q)
                S_IDLE, S_FILL, S_RUN: begin
                    if (acc) begin
                        col_q  <= col_d;
                        nr_q   <= nr_d;
                        wptr_q <= wptr_d;
                        if (in_last)                         state_q <= (PAD_MODE != 0) ? S_DRAIN : S_DONE;
                        else if (nr_d >= 16'(START_ROW))     state_q <= S_RUN;
                        else                                 state_q <= S_FILL;
                    end
                end
                S_DRAIN: begin
                    if (ld) begin
                        col_q  <= col_d;
                        nr_q   <= nr_d;
                        wptr_q <= wptr_d;
                        if (drain_last) state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (slot_free) begin
                        fd_q    <= 1'b1;
                        state_q <= S_IDLE;
                        nr_q    <= '0;
                        col_q   <= '0;
                        wptr_q  <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout_win   = win_q;
    assign dout_vld   = vld_q;
    assign out_row    = orow_q;
    assign out_col    = ocol_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_sc_row_window.sv
// Directed bench: three window configurations (K3 valid-only, K3 zero-pad, K5 zero-pad),
// each with its own driver/monitor checking every output beat against the expected window.
module tb_sc_row_window;

    localparam int BW    = 32;
    localparam int ST    = 5;
    localparam int ROW   = 8;
    localparam int COL   = 10;
    localparam int NB    = COL / ST;
    localparam int W     = ST * BW;
    localparam int NBEAT = ROW * NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   frames_req [3];
    logic rst_c      [3];
    logic rdy_tog    [3];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word = {tag,row,beat,lane}; tag changes only when a frame is abandoned by reset.
    function automatic logic [W-1:0] beat_word(input int tag, input int r, input int b, input bit ones);
        logic [W-1:0] v;
        v = '0;
        for (int l = 0; l < ST; l++)
            v[l*BW +: BW] = ones ? {BW{1'b1}} : {8'(tag), 8'(r), 8'(b), 8'(l)};
        return v;
    endfunction

    for (genvar u = 0; u < 3; u++) begin : g
        localparam int KU   = (u == 2) ? 5 : 3;
        localparam int HU   = (KU - 1) / 2;
        localparam int PU   = (u == 0) ? 0 : 1;
        localparam bit ONES = (u == 2);
        localparam int NOUT = (PU != 0) ? ROW * NB : (ROW - KU + 1) * NB;
        localparam int ROW0 = (PU != 0) ? 0 : HU;

        logic            reset, din_ready, din_ack, dout_vld, dout_ready, frame_done;
        logic [W-1:0]    din;
        logic [KU*W-1:0] dout_win;
        logic [15:0]     out_row, out_col;
        int              bidx, tag, outs, fd_cnt, in_frame, sent, gap;

        sc_row_window #(.BW(BW), .ST(ST), .ROW(ROW), .COL(COL), .K(KU), .PAD_MODE(PU)) dut (
            .clock      (clk),
            .reset      (reset),
            .din_ready  (din_ready),
            .din        (din),
            .din_ack    (din_ack),
            .dout_win   (dout_win),
            .dout_vld   (dout_vld),
            .dout_ready (dout_ready),
            .out_row    (out_row),
            .out_col    (out_col),
            .frame_done (frame_done)
        );

        initial begin
            bit tg;
            int c, b, r;
            reset = 1'b1; din_ready = 1'b0; din = '0; dout_ready = 1'b1;
            bidx = 0; tag = 0; outs = 0; fd_cnt = 0; in_frame = 0; sent = 0; gap = 0; tg = 1'b0;
            forever begin
                @(negedge clk);
                if (rst_c[u]) begin
                    reset     = 1'b1;
                    din_ready = 1'b0;
                    if (bidx > 0 || in_frame > 0) tag++;
                    bidx = 0; in_frame = 0; gap = 0;
                end else begin
                    reset      = 1'b0;
                    tg         = ~tg;
                    dout_ready = rdy_tog[u] ? tg : 1'b1;
                    din_ready  = (gap == 0) ? (sent < frames_req[u]) : (PU != 0);
                    din        = beat_word(tag, bidx / NB, bidx % NB, ONES);
                    #1;
                    if (gap > 0) begin
                        if (din_ready) chk("drain_ack", din_ack, 0);
                        gap--;
                    end else if (din_ready && din_ack) begin
                        if (bidx == NBEAT - 1) begin
                            bidx = 0; sent++;
                            gap  = (PU != 0) ? HU * NB : 1;
                        end else begin
                            bidx++;
                        end
                    end
                    // A pending beat must show the next expected window, stalled or not.
                    if (dout_vld) begin
                        c = ROW0 + in_frame / NB;
                        b = in_frame % NB;
                        chk("out_row", out_row, c);
                        chk("out_col", out_col, b);
                        for (int j = 0; j < KU; j++) begin
                            r = c - HU + j;
                            chk($sformatf("slice%0d", j), dout_win[j*W +: W],
                                (r >= 0 && r < ROW) ? beat_word(tag, r, b, ONES) : '0);
                        end
                        if (dout_ready) begin
                            in_frame++; outs++;
                        end
                    end
                    if (frame_done) begin
                        chk("frame_len", in_frame, NOUT);
                        in_frame = 0; fd_cnt++;
                    end
                end
            end
        end
    end

    function automatic int fd_of(input int u);
        case (u)
            0:       return g[0].fd_cnt;
            1:       return g[1].fd_cnt;
            default: return g[2].fd_cnt;
        endcase
    endfunction

    function automatic int outs_of(input int u);
        case (u)
            0:       return g[0].outs;
            1:       return g[1].outs;
            default: return g[2].outs;
        endcase
    endfunction

    task automatic wait_fd(input int u, input int target, input int total_outs);
        for (int i = 0; i < 3000 && fd_of(u) < target; i++) begin
            @(negedge clk); #2;
        end
        repeat (3) begin @(negedge clk); #2; end
        chk($sformatf("fd_cnt%0d", u), fd_of(u), target);
        chk($sformatf("outs%0d", u), outs_of(u), total_outs);
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            frames_req[u] = 0; rst_c[u] = 1'b1; rdy_tog[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #2;
        chk("rst_vld",  g[0].dout_vld, 0);
        chk("rst_ack",  g[0].din_ack, 0);
        chk("rst_fd",   g[0].frame_done, 0);
        chk("rst_row",  g[0].out_row, 0);
        chk("rst_col",  g[0].out_col, 0);
        chk("rst_win",  g[0].dout_win[W-1:0], 0);
        chk("rst_vld2", g[2].dout_vld, 0);
        chk("rst_win2", g[2].dout_win[4*W +: W], 0);
        for (int u = 0; u < 3; u++) rst_c[u] = 1'b0;
        @(negedge clk); #2;

        // 1: valid-only, full throughput
        frames_req[0] = 1;
        wait_fd(0, 1, 12);
        // 3: 1010 backpressure
        rdy_tog[0] = 1'b1;
        frames_req[0] = 2;
        wait_fd(0, 2, 24);
        rdy_tog[0] = 1'b0;
        // 6: two frames separated by one idle cycle
        frames_req[0] = 4;
        wait_fd(0, 4, 48);

        // 2: zero-pad with drain
        frames_req[1] = 1;
        wait_fd(1, 1, 16);
        // 4: reset in the middle of a frame, then a clean frame
        frames_req[1] = 2;
        for (int i = 0; i < 200 && g[1].bidx < 9; i++) begin
            @(negedge clk); #2;
        end
        chk("t4_reached_beat9", (g[1].bidx >= 9), 1);
        rst_c[1] = 1'b1;
        repeat (2) begin @(negedge clk); #2; end
        rst_c[1] = 1'b0;
        for (int i = 0; i < 3000 && fd_of(1) < 2; i++) begin
            @(negedge clk); #2;
        end
        chk("fd_cnt1_after_reset", fd_of(1), 2);

        // 5: K=5 zero-pad, all-ones data
        frames_req[2] = 1;
        wait_fd(2, 1, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
